pc_alu_datapath: RTL and testbench

Execution-and-sequencing slice of the 8-bit micro-processor core. It holds the 8-bit program counter and provides the combinational ALU with its zero flag. It also computes the PC-relative jump target and selects the next PC from the ALU-conditioned branch or the stack return path. It sits between the instruction decoder, register file, stack and instruction ROM.

---
 rtl/pc_alu_datapath.sv | 54 +++++
 tb/tb_pc_alu_datapath.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_alu_datapath.sv
// Execution and sequencing slice of the 8-bit core: program counter, ALU with zero flag,
// PC-relative jump adder and next-PC selection between branch, stack return and increment.
module pc_alu_datapath (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] c_alu,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_cond,
  input  logic       c_stack,
  input  logic [7:0] j_offset,
  input  logic [7:0] pc_stack,
  output logic [7:0] pc_count,
  output logic [7:0] pc_jump,
  output logic [7:0] d_alu,
  output logic       zero
);

  logic [7:0] pc_q;
  logic [7:0] pc_d;
  logic [7:0] pc_load;
  logic       load;

  always_comb begin
    d_alu = 8'h00;
    case (c_alu)
      2'b00:   d_alu = a + b;
      2'b01:   d_alu = a - b;
      2'b10:   d_alu = a & b;
      default: d_alu = a | b;
    endcase
  end

  assign zero = (d_alu == 8'h00);

  // Offset is two's complement; the 8-bit wrap makes 8'h80..8'hFF jump backwards.
  assign pc_jump = pc_q + j_offset;

  // A stack return wins over a taken conditional branch.
  assign load    = (c_cond & zero) | c_stack;
  assign pc_load = c_stack ? pc_stack : pc_jump;
  assign pc_d    = load ? pc_load : pc_q + 8'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= 8'h00;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_count = pc_q;

endmodule

// File: tb/tb_pc_alu_datapath.sv
// Scoreboard bench for pc_alu_datapath: expected values are queued when stimulus is
// applied and popped when the DUT output is sampled.
module tb_pc_alu_datapath;

  logic       clk;
  logic       reset;
  logic [1:0] c_alu;
  logic [7:0] a;
  logic [7:0] b;
  logic       c_cond;
  logic       c_stack;
  logic [7:0] j_offset;
  logic [7:0] pc_stack;
  logic [7:0] pc_count;
  logic [7:0] pc_jump;
  logic [7:0] d_alu;
  logic       zero;

  typedef struct {
    string      name;
    logic [7:0] val;
    logic       z;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks;
  int   n_errors;

  pc_alu_datapath dut (
    .clk      (clk),
    .reset    (reset),
    .c_alu    (c_alu),
    .a        (a),
    .b        (b),
    .c_cond   (c_cond),
    .c_stack  (c_stack),
    .j_offset (j_offset),
    .pc_stack (pc_stack),
    .pc_count (pc_count),
    .pc_jump  (pc_jump),
    .d_alu    (d_alu),
    .zero     (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string name, input logic [7:0] val, input logic z);
    exp_t x;
    x.name = name;
    x.val  = val;
    x.z    = z;
    sb.push_back(x);
  endtask

  // Returns 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    j_offset = 8'h07;
    #2;
    push("reset_pc", 8'h00, 1'b0);
    e = sb.pop_front(); n_checks++;
    if (pc_count !== e.val) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", e.name, pc_count, e.val);
    end
    push("reset_pc_jump", 8'h07, 1'b0);
    e = sb.pop_front(); n_checks++;
    if (pc_jump !== e.val) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", e.name, pc_jump, e.val);
    end
    // A pending stack load must be ignored while reset is held.
    c_stack  = 1'b1;
    pc_stack = 8'h55;
    for (int i = 0; i < 3; i++) begin
      push("reset_hold", 8'h00, 1'b0);
      tick();
      e = sb.pop_front(); n_checks++;
      if (pc_count !== e.val) begin
        n_errors++;
        $display("FAIL %s[%0d]: got %02h expected %02h", e.name, i, pc_count, e.val);
      end
    end
    c_stack  = 1'b0;
    j_offset = 8'h00;
    reset    = 1'b1;
  endtask

  task automatic test_increment();
    for (int i = 1; i <= 3; i++) begin
      push("incr", 8'(i), 1'b0);
      tick();
      e = sb.pop_front(); n_checks++;
      if (pc_count !== e.val) begin
        n_errors++;
        $display("FAIL %s[%0d]: got %02h expected %02h", e.name, i, pc_count, e.val);
      end
    end
    c_stack  = 1'b1;
    pc_stack = 8'hFF;
    push("load_ff", 8'hFF, 1'b0);
    tick();
    e = sb.pop_front(); n_checks++;
    if (pc_count !== e.val) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", e.name, pc_count, e.val);
    end
    c_stack = 1'b0;
    push("wrap", 8'h00, 1'b0);
    tick();
    e = sb.pop_front(); n_checks++;
    if (pc_count !== e.val) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", e.name, pc_count, e.val);
    end
  endtask

  task automatic test_alu();
    logic [7:0] exp_ops [4];
    exp_ops[0] = 8'h11;
    exp_ops[1] = 8'h07;
    exp_ops[2] = 8'h04;
    exp_ops[3] = 8'h0D;
    a = 8'h0C;
    b = 8'h05;
    for (int i = 0; i < 4; i++) begin
      c_alu = 2'(i);
      push($sformatf("alu_op%0d", i), exp_ops[i], 1'b0);
      #1;
      e = sb.pop_front(); n_checks++;
      if (d_alu !== e.val || zero !== e.z) begin
        n_errors++;
        $display("FAIL %s: got d_alu=%02h zero=%b expected d_alu=%02h zero=%b",
                 e.name, d_alu, zero, e.val, e.z);
      end
    end
    a     = 8'h33;
    b     = 8'h33;
    c_alu = 2'b01;
    push("alu_sub_self", 8'h00, 1'b1);
    #1;
    e = sb.pop_front(); n_checks++;
    if (d_alu !== e.val || zero !== e.z) begin
      n_errors++;
      $display("FAIL %s: got d_alu=%02h zero=%b expected d_alu=%02h zero=%b",
               e.name, d_alu, zero, e.val, e.z);
    end
    a     = 8'hFF;
    b     = 8'h01;
    c_alu = 2'b00;
    push("alu_add_wrap", 8'h00, 1'b1);
    #1;
    e = sb.pop_front(); n_checks++;
    if (d_alu !== e.val || zero !== e.z) begin
      n_errors++;
      $display("FAIL %s: got d_alu=%02h zero=%b expected d_alu=%02h zero=%b",
               e.name, d_alu, zero, e.val, e.z);
    end
  endtask

  // Each branch case first loads PC=8'h10 through the stack path.
  task automatic test_branch();
    logic [7:0] offs  [3];
    logic [7:0] a_in  [3];
    logic [7:0] jmp   [3];
    logic [7:0] nxt   [3];
    offs[0] = 8'h05; a_in[0] = 8'h00; jmp[0] = 8'h15; nxt[0] = 8'h15;
    offs[1] = 8'h05; a_in[1] = 8'h01; jmp[1] = 8'h15; nxt[1] = 8'h11;
    offs[2] = 8'hFE; a_in[2] = 8'h00; jmp[2] = 8'h0E; nxt[2] = 8'h0E;
    for (int i = 0; i < 3; i++) begin
      c_cond   = 1'b0;
      c_stack  = 1'b1;
      pc_stack = 8'h10;
      push($sformatf("br%0d_setup", i), 8'h10, 1'b0);
      tick();
      e = sb.pop_front(); n_checks++;
      if (pc_count !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %02h expected %02h", e.name, pc_count, e.val);
      end
      c_stack  = 1'b0;
      c_cond   = 1'b1;
      c_alu    = 2'b00;
      a        = a_in[i];
      b        = 8'h00;
      j_offset = offs[i];
      push($sformatf("br%0d_pc_jump", i), jmp[i], 1'b0);
      #1;
      e = sb.pop_front(); n_checks++;
      if (pc_jump !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %02h expected %02h", e.name, pc_jump, e.val);
      end
      push($sformatf("br%0d_next", i), nxt[i], 1'b0);
      tick();
      e = sb.pop_front(); n_checks++;
      if (pc_count !== e.val) begin
        n_errors++;
        $display("FAIL %s: got %02h expected %02h", e.name, pc_count, e.val);
      end
    end
    c_cond = 1'b0;
  endtask

  task automatic test_stack();
    c_stack  = 1'b1;
    pc_stack = 8'h42;
    c_cond   = 1'b1;
    c_alu    = 2'b00;
    a        = 8'h00;
    b        = 8'h00;
    j_offset = 8'h05;
    push("stack_priority", 8'h42, 1'b0);
    tick();
    e = sb.pop_front(); n_checks++;
    if (pc_count !== e.val) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", e.name, pc_count, e.val);
    end
    c_stack = 1'b0;
    c_cond  = 1'b0;
    push("stack_resume", 8'h43, 1'b0);
    tick();
    e = sb.pop_front(); n_checks++;
    if (pc_count !== e.val) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", e.name, pc_count, e.val);
    end
  endtask

  task automatic test_async_reset();
    c_stack  = 1'b1;
    pc_stack = 8'h27;
    push("async_setup", 8'h27, 1'b0);
    tick();
    e = sb.pop_front(); n_checks++;
    if (pc_count !== e.val) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", e.name, pc_count, e.val);
    end
    c_stack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    push("async_drop", 8'h00, 1'b0);
    #1;
    e = sb.pop_front(); n_checks++;
    if (pc_count !== e.val) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", e.name, pc_count, e.val);
    end
    #1;
    reset = 1'b1;
    push("async_release", 8'h01, 1'b0);
    tick();
    e = sb.pop_front(); n_checks++;
    if (pc_count !== e.val) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", e.name, pc_count, e.val);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b0;
    c_alu    = 2'b00;
    a        = 8'h00;
    b        = 8'h00;
    c_cond   = 1'b0;
    c_stack  = 1'b0;
    j_offset = 8'h00;
    pc_stack = 8'h00;
    test_reset();
    test_increment();
    test_alu();
    test_branch();
    test_stack();
    test_async_reset();
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
